// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - miss request, memory read and line delivery signals of the refill engine
interface icache_refill_if;
  logic         miss_req;
  logic [63:0]  miss_addr;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         line_valid;
  logic [63:0]  line_addr;
  logic [127:0] data_line;
  logic         busy;
  logic         err;

  modport slave (
    input  miss_req, miss_addr, mem_ready, mem_rdata,
    output mem_req, mem_addr, line_valid, line_addr, data_line, busy, err
  );

  modport master (
    output miss_req, miss_addr, mem_ready, mem_rdata,
    input  mem_req, mem_addr, line_valid, line_addr, data_line, busy, err
  );
endinterface

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - fetches a 16-byte instruction line as four 32-bit word reads
module icache_refill #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  icache_refill_if.slave   bus
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [63:0]    base_q, base_d;
  logic [63:0]    mem_addr_q, mem_addr_d;
  logic [63:0]    line_addr_q, line_addr_d;
  logic [127:0]   line_q, line_d;
  logic           err_c;
  logic [1:0]     k_inc;

  assign k_inc = k_q + 2'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      wait_q      <= '0;
      base_q      <= 64'd0;
      mem_addr_q  <= 64'd0;
      line_addr_q <= 64'd0;
      line_q      <= 128'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      line_addr_q <= line_addr_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wait_d      = wait_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    line_addr_d = line_addr_q;
    line_d      = line_q;
    err_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          base_d     = bus.miss_addr & ~64'hF;
          mem_addr_d = bus.miss_addr & ~64'hF;
          k_d        = 2'd0;
          wait_d     = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (bus.mem_ready) begin
          line_d[{k_q, 5'b00000} +: 32] = bus.mem_rdata;
          wait_d = '0;
          k_d    = k_inc;
          if (k_q == 2'd3) begin
            line_addr_d = base_q;
            state_d     = FILL;
          end else begin
            // mem_addr is registered so it keeps the last word address once FETCH ends
            mem_addr_d = base_q + {60'd0, k_inc, 2'b00};
          end
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          err_c   = 1'b1;
          wait_d  = '0;
          k_d     = 2'd0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req    = (state_q == FETCH);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.line_valid = (state_q == FILL);
  assign bus.line_addr  = line_addr_q;
  assign bus.data_line  = line_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_c;

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - self-checking bench for icache_refill
module tb_icache_refill;

  typedef struct {
    logic [63:0]       addr;
    int                waits;
    logic [3:0][31:0]  w;
    logic [63:0]       exp_laddr;
    logic [127:0]      exp_line;
    int                exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0]  laddr;
    logic [127:0] line;
  } sb_t;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_fail;
  int   err_cnt;
  sb_t  sb[$];
  vec_t vecs[4];
  vec_t v40;
  vec_t v2000;
  vec_t v1234;
  vec_t vchain;

  icache_refill_if bus ();

  icache_refill #(.TIMEOUT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (bus.err === 1'b1) err_cnt++;
    if (bus.line_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_line: got line_addr %h expected no line_valid", bus.line_addr);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("line_addr", bus.line_addr, e.laddr);
        check("data_line", bus.data_line, e.line);
      end
    end
  end

  task automatic do_refill(input vec_t v, input bit alt_miss, input logic [63:0] alt_addr,
                           input bit next_miss, input logic [63:0] next_addr);
    int  j;
    int  wc;
    int  n;
    bit  done;
    bus.miss_req  = 1'b1;
    bus.miss_addr = v.addr;
    sb.push_back('{v.exp_laddr, v.exp_line});
    step();
    j = 0; wc = 0; n = 0; done = 1'b0;
    while (!done && n < 200) begin
      check("busy", bus.busy, 1);
      if (bus.line_valid) begin
        check("latency", n + 1, v.exp_lat);
        bus.miss_req  = next_miss;
        bus.miss_addr = next_addr;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_0000;
        done = 1'b1;
      end else begin
        check("mem_req", bus.mem_req, 1);
        check("mem_addr", bus.mem_addr, v.exp_laddr + 64'(4 * j));
        bus.miss_req  = alt_miss;
        bus.miss_addr = alt_miss ? alt_addr : v.addr;
        bus.mem_ready = (wc == v.waits);
        if (j < 4) bus.mem_rdata = v.w[j];
        else       bus.mem_rdata = 32'hDEAD_0000;
        if (wc == v.waits) begin j++; wc = 0; end
        else wc++;
      end
      step();
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL line_valid_timeout: got no line_valid expected one within %0d cycles", n);
    end
    check("post_fill_line_valid", bus.line_valid, 0);
    check("post_fill_busy", bus.busy, 0);
    check("post_fill_mem_req", bus.mem_req, 0);
    check("post_fill_mem_addr_hold", bus.mem_addr, v.exp_laddr + 64'hC);
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err;
    int e0;
    n_cmp = 0; n_fail = 0; err_cnt = 0;
    reset_n = 1'b0;
    bus.miss_req = 1'b0; bus.miss_addr = 64'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;

    vecs[0] = '{64'h0000_0000_0000_1234, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                64'h0000_0000_0000_1230, 128'h000000A3_000000A2_000000A1_000000A0, 5};
    vecs[1] = '{64'h0000_0000_0000_1234, 3, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                64'h0000_0000_0000_1230, 128'h000000A3_000000A2_000000A1_000000A0, 17};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000},
                64'hFFFF_FFFF_FFFF_FFF0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 9};
    vecs[3] = '{64'h0000_0000_DEAD_BEEF, 2, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                64'h0000_0000_DEAD_BEE0, 128'h44444444_33333333_22222222_11111111, 13};
    v1234  = vecs[0];
    v2000  = '{64'h0000_0000_0000_2000, 0, {32'hB3, 32'hB2, 32'hB1, 32'hB0},
               64'h0000_0000_0000_2000, 128'h000000B3_000000B2_000000B1_000000B0, 5};
    vchain = '{64'h0000_0000_0000_5678, 0, {32'hC3, 32'hC2, 32'hC1, 32'hC0},
               64'h0000_0000_0000_5670, 128'h000000C3_000000C2_000000C1_000000C0, 5};
    v40    = '{64'h0000_0000_0000_0040, 0, {32'h0000_0D03, 32'h0000_0D02, 32'h0000_0D01, 32'h0000_0D00},
               64'h0000_0000_0000_0040, 128'h00000D03_00000D02_00000D01_00000D00, 5};

    #2;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_line_valid", bus.line_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_line_addr", bus.line_addr, 0);
    check("rst_data_line", bus.data_line, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      do_refill(vecs[i], 1'b0, 64'd0, 1'b0, 64'd0);
      step();
    end

    // timeout: mem_ready never rises, err expected in the fourth FETCH cycle
    e0 = err_cnt;
    first_err = -1;
    bus.miss_req = 1'b1; bus.miss_addr = 64'h3004; bus.mem_ready = 1'b0;
    step();
    bus.miss_req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.err && first_err < 0) first_err = n;
      if (n == 4) check("timeout_busy_drop", bus.busy, 0);
      step();
    end
    check("timeout_err_cycle", first_err, 3);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_data_line_kept", bus.data_line, 128'h44444444_33333333_22222222_11111111);
    check("timeout_line_addr_kept", bus.line_addr, 64'hDEAD_BEE0);

    do_refill(v1234, 1'b1, 64'h2000, 1'b0, 64'd0);
    for (int n = 0; n < 3; n++) begin
      check("ignored_miss_idle", bus.busy, 0);
      step();
    end
    do_refill(v2000, 1'b0, 64'd0, 1'b0, 64'd0);
    step();

    do_refill(v1234, 1'b0, 64'd0, 1'b1, vchain.addr);
    do_refill(vchain, 1'b0, 64'd0, 1'b0, 64'd0);
    step();

    bus.miss_req = 1'b1; bus.miss_addr = 64'h1234;
    step();
    bus.miss_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_00E0;
    step();
    bus.mem_rdata = 32'h0000_00E1;
    step();
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_line_valid", bus.line_valid, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_line_addr", bus.line_addr, 0);
    check("midrst_data_line", bus.data_line, 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("midrst_idle_after_release", bus.busy, 0);
    do_refill(v40, 1'b0, 64'd0, 1'b0, 64'd0);
    step();
    step();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
